// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the Gray counter family.
// Conversions operate on WIDTH_MAX-bit vectors; callers cast to their own width.
package gray_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
    logic [WIDTH_MAX-1:0] b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder of configurable width.
module gray_encode
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(WIDTH_MAX'(bin_i)));

endmodule

// File: rtl/gray_counter_gen.sv
// Up/down Gray counter with load, sticky wrap flag and registered Gray output.
// Define GRAY_SATURATE_EN to hold at the limits instead of wrapping.
module gray_counter_gen
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             OvfClr,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_counter_gen: WIDTH out of legal range");
  end

`ifdef GRAY_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [WIDTH-1:0] BIN_RST  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] GRAY_RST = WIDTH'(bin2gray(WIDTH_MAX'(RESET_VAL)));
  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             limit_hit;

  always_comb begin
    bin_d     = bin_q;
    limit_hit = 1'b0;
    if (Load) begin
      bin_d = LoadVal;
    end else if (En) begin
      if (Dir) begin
        limit_hit = (bin_q == BIN_MAX);
        bin_d     = (limit_hit && SATURATE) ? bin_q : bin_q + BIN_ONE;
      end else begin
        limit_hit = (bin_q == '0);
        bin_d     = (limit_hit && SATURATE) ? bin_q : bin_q - BIN_ONE;
      end
    end
    // A wrap on the same edge as a clear wins, so the event is never lost.
    ovf_d = limit_hit | (ovf_q & ~OvfClr);
  end

  gray_encode #(.WIDTH(WIDTH)) u_encode (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin_q  <= BIN_RST;
      gray_q <= GRAY_RST;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Output   = gray_q;
  assign Overflow = ovf_q;

endmodule
